// File: rtl/riscv_idu_if.sv
// Fetch-to-decode bundle for riscv_idu: fetch beats in, decoded
// instruction out over valid/ready, plus queue status.
interface riscv_idu_if;
    logic        ifu_vld;
    logic [31:0] ifu_addr;
    logic [31:0] ifu_data;
    logic        flush;
    logic        dec_vld;
    logic        dec_rdy;
    logic [31:0] dec_addr;
    logic [31:0] dec_instr;
    logic        dec_c;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic [2:0]  dec_fmt;
    logic        dec_illegal;
    logic        idu_afull;
    logic        idu_ovf;

    modport master (
        output ifu_vld, ifu_addr, ifu_data, flush, dec_rdy,
        input  dec_vld, dec_addr, dec_instr, dec_c,
        input  dec_rd, dec_rs1, dec_rs2, dec_imm, dec_fmt,
        input  dec_illegal, idu_afull, idu_ovf
    );

    modport slave (
        input  ifu_vld, ifu_addr, ifu_data, flush, dec_rdy,
        output dec_vld, dec_addr, dec_instr, dec_c,
        output dec_rd, dec_rs1, dec_rs2, dec_imm, dec_fmt,
        output dec_illegal, idu_afull, idu_ovf
    );
endinterface

// File: rtl/riscv_idu.sv
// RV32 decode unit: fetch queue, RVC expander, field/immediate decode.
// Define RISCV_IDU_RVC_EN to compile in the compressed expander.
module riscv_idu #(
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 2
) (
    input  logic        clock,
    input  logic        reset,
    riscv_idu_if.slave  idu_io
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    logic [63:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        afull_q, afull_d;
    logic        ovf_q, ovf_d;

    logic [AW:0] occ, occ_d;
    logic        empty, full;
    logic        push_req, push, pop;

    assign occ   = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign push_req = idu_io.ifu_vld && !idu_io.flush;
    assign pop      = !empty && idu_io.dec_rdy && !idu_io.flush;
    // A full queue can still take a beat when the head leaves this cycle.
    assign push     = push_req && (!full || pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ;
        ovf_d  = ovf_q;
        if (idu_io.flush) begin
            rptr_d = wptr_q;
            occ_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            occ_d = occ + (AW+1)'(push) - (AW+1)'(pop);
        end
        if (push_req && !push) ovf_d = 1'b1;
        afull_d = (occ_d >= (AW+1)'(AFULL_LVL));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset)
            mem_q[wptr_q[AW-1:0]] <= {idu_io.ifu_addr, idu_io.ifu_data};
    end

`ifdef RISCV_IDU_RVC_EN
    function automatic logic [31:0] enc_i(
        input logic [11:0] imm, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd,
        input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(
        input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(
        input logic [11:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
    endfunction

    // o holds offset[12:1]
    function automatic logic [31:0] enc_b(
        input logic [11:0] o, input logic [4:0] rs1,
        input logic [2:0] f3);
        return {o[11], o[9:4], 5'd0, rs1, f3, o[3:0], o[10], OP_BRANCH};
    endfunction

    // o holds offset[20:1]
    function automatic logic [31:0] enc_j(
        input logic [19:0] o, input logic [4:0] rd);
        return {o[19], o[9:0], o[10], o[18:11], rd, OP_JAL};
    endfunction

    function automatic logic [32:0] rvc_expand(input logic [15:0] c);
        logic [4:0]  rd, rs2, rdp, rs1p;
        logic [11:0] i6, ldw, a4s, a16, lsp, ssp;
        logic [19:0] jo;
        logic [11:0] bo;
        logic [2:0]  af3;
        logic [6:0]  af7;
        logic [31:0] ins;
        logic        ill;
        rd   = c[11:7];
        rs2  = c[6:2];
        rdp  = {2'b01, c[4:2]};
        rs1p = {2'b01, c[9:7]};
        i6   = {{6{c[12]}}, c[12], c[6:2]};
        ldw  = {5'b0, c[5], c[12:10], c[6], 2'b00};
        a4s  = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
        a16  = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0};
        lsp  = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
        ssp  = {4'b0, c[8:7], c[12:9], 2'b00};
        jo   = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2],
                c[11], c[5:3]};
        bo   = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3]};
        af7  = (c[6:5] == 2'b00) ? 7'b0100000 : 7'b0000000;
        case (c[6:5])
            2'b00:   af3 = 3'b000;
            2'b01:   af3 = 3'b100;
            2'b10:   af3 = 3'b110;
            default: af3 = 3'b111;
        endcase
        ins = '0;
        ill = 1'b0;
        case ({c[1:0], c[15:13]})
            5'b00_000: begin
                ill = (a4s == '0);
                ins = enc_i(a4s, 5'd2, 3'b000, rdp, OP_IMM);
            end
            5'b00_010: ins = enc_i(ldw, rs1p, 3'b010, rdp, OP_LOAD);
            5'b00_110: ins = enc_s(ldw, rdp, rs1p);
            5'b01_000: ins = enc_i(i6, rd, 3'b000, rd, OP_IMM);
            5'b01_001: ins = enc_j(jo, 5'd1);
            5'b01_010: ins = enc_i(i6, 5'd0, 3'b000, rd, OP_IMM);
            5'b01_011: begin
                if (rd == 5'd2) begin
                    ill = (a16 == '0);
                    ins = enc_i(a16, 5'd2, 3'b000, 5'd2, OP_IMM);
                end else begin
                    ill = (i6 == '0);
                    ins = {{14{c[12]}}, c[12], c[6:2], rd, OP_LUI};
                end
            end
            5'b01_100: begin
                case (c[11:10])
                    2'b00: begin
                        ill = c[12];
                        ins = enc_r(7'b0, rs2, rs1p, 3'b101, rs1p, OP_IMM);
                    end
                    2'b01: begin
                        ill = c[12];
                        ins = enc_r(7'b0100000, rs2, rs1p, 3'b101,
                                    rs1p, OP_IMM);
                    end
                    2'b10: ins = enc_i(i6, rs1p, 3'b111, rs1p, OP_IMM);
                    default: begin
                        ill = c[12];
                        ins = enc_r(af7, rdp, rs1p, af3, rs1p, OP_OP);
                    end
                endcase
            end
            5'b01_101: ins = enc_j(jo, 5'd0);
            5'b01_110: ins = enc_b(bo, rs1p, 3'b000);
            5'b01_111: ins = enc_b(bo, rs1p, 3'b001);
            5'b10_000: begin
                ill = c[12];
                ins = enc_r(7'b0, rs2, rd, 3'b001, rd, OP_IMM);
            end
            5'b10_010: begin
                ill = (rd == 5'd0);
                ins = enc_i(lsp, 5'd2, 3'b010, rd, OP_LOAD);
            end
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin
                        ill = (rd == 5'd0);
                        ins = enc_i(12'd0, rd, 3'b000, 5'd0, OP_JALR);
                    end else begin
                        ins = enc_r(7'b0, rs2, 5'd0, 3'b000, rd, OP_OP);
                    end
                end else if (rs2 == 5'd0) begin
                    if (rd == 5'd0) ins = 32'h0010_0073;
                    else ins = enc_i(12'd0, rd, 3'b000, 5'd1, OP_JALR);
                end else begin
                    ins = enc_r(7'b0, rs2, rd, 3'b000, rd, OP_OP);
                end
            end
            5'b10_110: ins = enc_s(ssp, rs2, 5'd2);
            default:   ill = 1'b1;
        endcase
        return {ill, ill ? 32'd0 : ins};
    endfunction
`endif

    logic [31:0] hd_addr, hd_data;
    logic        vld, is_c, raw_ill, ill;
    logic [31:0] raw_ins, ins, imm;
    logic [2:0]  raw_fmt, fmt;

    assign {hd_addr, hd_data} = mem_q[rptr_q[AW-1:0]];
    assign vld  = !empty;
    assign is_c = (hd_data[1:0] != 2'b11);

`ifdef RISCV_IDU_RVC_EN
    logic [32:0] exp_w;
    assign exp_w   = rvc_expand(hd_data[15:0]);
    assign raw_ill = is_c && exp_w[32];
    assign raw_ins = is_c ? exp_w[31:0] : hd_data;
`else
    assign raw_ill = is_c;
    assign raw_ins = hd_data;
`endif

    always_comb begin
        raw_fmt = FMT_NONE;
        case (raw_ins[6:0])
            OP_LUI, OP_AUIPC:  raw_fmt = FMT_U;
            OP_JAL:            raw_fmt = FMT_J;
            OP_BRANCH:         raw_fmt = FMT_B;
            OP_STORE:          raw_fmt = FMT_S;
            OP_OP:             raw_fmt = FMT_R;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_MISC, OP_SYSTEM: raw_fmt = FMT_I;
            default:           raw_fmt = FMT_NONE;
        endcase
    end

    assign ill = raw_ill || (raw_fmt == FMT_NONE);
    assign ins = (vld && !ill) ? raw_ins : 32'd0;
    assign fmt = !vld ? 3'd0 : (ill ? FMT_NONE : raw_fmt);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                          ins[11:8], 1'b0};
            FMT_U: imm = {ins[31:12], 12'b0};
            FMT_J: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                          ins[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign idu_io.dec_vld     = vld;
    assign idu_io.dec_addr    = vld ? hd_addr : 32'd0;
    assign idu_io.dec_instr   = ins;
    assign idu_io.dec_c       = vld && is_c;
    assign idu_io.dec_rd      = ins[11:7];
    assign idu_io.dec_rs1     = ins[19:15];
    assign idu_io.dec_rs2     = ins[24:20];
    assign idu_io.dec_imm     = imm;
    assign idu_io.dec_fmt     = fmt;
    assign idu_io.dec_illegal = vld && ill;
    assign idu_io.idu_afull   = afull_q;
    assign idu_io.idu_ovf     = ovf_q;

endmodule

// File: tb/tb_riscv_idu.sv
// Directed bench for riscv_idu: latency, RVC expansion, illegal,
// overflow/almost-full, full push+pop, flush and mid-run reset.
module tb_riscv_idu;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tot = 0;
    int   n_pass = 0;

    riscv_idu_if bus ();

    riscv_idu #(.DEPTH(4), .AFULL_LVL(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .idu_io (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] d);
        bus.ifu_vld  = 1'b1;
        bus.ifu_addr = a;
        bus.ifu_data = d;
    endtask

    task automatic idle();
        bus.ifu_vld  = 1'b0;
        bus.ifu_addr = '0;
        bus.ifu_data = '0;
    endtask

    initial begin
        idle();
        bus.flush   = 1'b0;
        bus.dec_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_vld", {31'd0, bus.dec_vld}, 0);
        chk("rst_afull", {31'd0, bus.idu_afull}, 0);
        chk("rst_ovf", {31'd0, bus.idu_ovf}, 0);
        chk("rst_instr", bus.dec_instr, 0);

        // single addi, one-cycle latency
        bus.dec_rdy = 1'b1;
        beat(32'h200, 32'h0050_0093);
        tick();
        idle();
        chk("addi_vld", {31'd0, bus.dec_vld}, 1);
        chk("addi_instr", bus.dec_instr, 32'h0050_0093);
        chk("addi_addr", bus.dec_addr, 32'h200);
        chk("addi_rd", {27'd0, bus.dec_rd}, 1);
        chk("addi_rs1", {27'd0, bus.dec_rs1}, 0);
        chk("addi_imm", bus.dec_imm, 5);
        chk("addi_fmt", {29'd0, bus.dec_fmt}, 1);
        chk("addi_c", {31'd0, bus.dec_c}, 0);
        tick();
        chk("addi_gone", {31'd0, bus.dec_vld}, 0);

        // c.li a0,1
        bus.dec_rdy = 1'b0;
        beat(32'h204, 32'h0000_4505);
        tick();
        idle();
        chk("cli_c", {31'd0, bus.dec_c}, 1);
`ifdef RISCV_IDU_RVC_EN
        chk("cli_instr", bus.dec_instr, 32'h0010_0513);
        chk("cli_rd", {27'd0, bus.dec_rd}, 10);
        chk("cli_imm", bus.dec_imm, 1);
        chk("cli_ill", {31'd0, bus.dec_illegal}, 0);
`else
        chk("cli_ill", {31'd0, bus.dec_illegal}, 1);
        chk("cli_instr", bus.dec_instr, 0);
        chk("cli_fmt", {29'd0, bus.dec_fmt}, 7);
`endif
        bus.dec_rdy = 1'b1;
        tick();
        chk("cli_gone", {31'd0, bus.dec_vld}, 0);

        // back-to-back RVC stream: c.mv, c.ebreak, c.j 0
        beat(32'h208, 32'h0000_852E);
        tick();
        beat(32'h20A, 32'h0000_9002);
`ifdef RISCV_IDU_RVC_EN
        chk("cmv_instr", bus.dec_instr, 32'h00B0_0533);
        chk("cmv_fmt", {29'd0, bus.dec_fmt}, 0);
`else
        chk("cmv_ill", {31'd0, bus.dec_illegal}, 1);
`endif
        chk("cmv_addr", bus.dec_addr, 32'h208);
        tick();
        beat(32'h20C, 32'h0000_A001);
`ifdef RISCV_IDU_RVC_EN
        chk("cebrk_instr", bus.dec_instr, 32'h0010_0073);
        chk("cebrk_imm", bus.dec_imm, 1);
`else
        chk("cebrk_instr", bus.dec_instr, 0);
`endif
        chk("cebrk_addr", bus.dec_addr, 32'h20A);
        tick();
        idle();
`ifdef RISCV_IDU_RVC_EN
        chk("cj_instr", bus.dec_instr, 32'h0000_006F);
        chk("cj_fmt", {29'd0, bus.dec_fmt}, 5);
`else
        chk("cj_fmt", {29'd0, bus.dec_fmt}, 7);
`endif
        chk("cj_addr", bus.dec_addr, 32'h20C);
        tick();
        chk("stream_gone", {31'd0, bus.dec_vld}, 0);

        // 32-bit formats: sw, beq -4, lui
        beat(32'h210, 32'h0020_A423);
        tick();
        beat(32'h214, 32'hFE00_0EE3);
        chk("sw_fmt", {29'd0, bus.dec_fmt}, 2);
        chk("sw_imm", bus.dec_imm, 8);
        chk("sw_rs2", {27'd0, bus.dec_rs2}, 2);
        chk("sw_rs1", {27'd0, bus.dec_rs1}, 1);
        tick();
        beat(32'h218, 32'h1234_52B7);
        chk("beq_fmt", {29'd0, bus.dec_fmt}, 3);
        chk("beq_imm", bus.dec_imm, 32'hFFFF_FFFC);
        tick();
        idle();
        chk("lui_fmt", {29'd0, bus.dec_fmt}, 4);
        chk("lui_imm", bus.dec_imm, 32'h1234_5000);
        chk("lui_rd", {27'd0, bus.dec_rd}, 5);
        tick();

        // all-zero halfword is illegal but still flows
        bus.dec_rdy = 1'b0;
        beat(32'h220, 32'h0000_0000);
        tick();
        idle();
        chk("zero_vld", {31'd0, bus.dec_vld}, 1);
        chk("zero_ill", {31'd0, bus.dec_illegal}, 1);
        chk("zero_fmt", {29'd0, bus.dec_fmt}, 7);
        chk("zero_instr", bus.dec_instr, 0);
        tick();
        chk("zero_held", {31'd0, bus.dec_vld}, 1);
        bus.dec_rdy = 1'b1;
        tick();
        chk("zero_popped", {31'd0, bus.dec_vld}, 0);

        // five beats into a stalled queue of four
        bus.dec_rdy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            beat(32'h300 + 32'(4 * k), (32'(k) << 20) | 32'h093);
            tick();
            if (k == 1) chk("afull_b1", {31'd0, bus.idu_afull}, 0);
            if (k == 2) chk("afull_b2", {31'd0, bus.idu_afull}, 1);
            if (k == 4) chk("ovf_b4", {31'd0, bus.idu_ovf}, 0);
            if (k == 5) chk("ovf_b5", {31'd0, bus.idu_ovf}, 1);
        end
        idle();
        bus.dec_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_order", bus.dec_addr, 32'h300 + 32'(4 * k));
            chk("ovf_imm", bus.dec_imm, 32'(k));
            tick();
        end
        chk("ovf_drained", {31'd0, bus.dec_vld}, 0);
        chk("ovf_sticky", {31'd0, bus.idu_ovf}, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("ovf_flush", {31'd0, bus.idu_ovf}, 1);

        // reset with entries queued
        bus.dec_rdy = 1'b0;
        beat(32'h3F0, 32'h0000_0013);
        tick();
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_vld", {31'd0, bus.dec_vld}, 0);
        chk("mrst_ovf", {31'd0, bus.idu_ovf}, 0);
        chk("mrst_afull", {31'd0, bus.idu_afull}, 0);

        // full queue with push and pop together
        for (int k = 1; k <= 4; k++) begin
            beat(32'h400 + 32'(4 * k), 32'h0000_0013);
            tick();
        end
        beat(32'h414, 32'h0000_0013);
        bus.dec_rdy = 1'b1;
        tick();
        idle();
        chk("fpp_ovf", {31'd0, bus.idu_ovf}, 0);
        chk("fpp_afull", {31'd0, bus.idu_afull}, 1);
        for (int k = 2; k <= 5; k++) begin
            chk("fpp_order", bus.dec_addr, 32'h400 + 32'(4 * k));
            tick();
        end
        chk("fpp_drained", {31'd0, bus.dec_vld}, 0);

        // flush with three queued and a same-cycle beat
        bus.dec_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat(32'h500 + 32'(4 * k), 32'h0000_0013);
            tick();
        end
        beat(32'h5FC, 32'h0000_0013);
        bus.flush = 1'b1;
        bus.dec_rdy = 1'b1;
        tick();
        idle();
        bus.flush = 1'b0;
        chk("fl_vld", {31'd0, bus.dec_vld}, 0);
        chk("fl_afull", {31'd0, bus.idu_afull}, 0);
        tick();
        chk("fl_vld2", {31'd0, bus.dec_vld}, 0);
        beat(32'h600, 32'h0000_0013);
        tick();
        idle();
        chk("fl_next", bus.dec_addr, 32'h600);
        tick();
        chk("fl_end", {31'd0, bus.dec_vld}, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
